// File: rtl/data_chk_pkg.sv
// data_chk_pkg: shared types and widths for the data_chk stream checker.
// State encoding, data width and match/miss counter width.
package data_chk_pkg;

   localparam int DATA_W = 8;
   localparam int MC_W   = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SYNC   = 2'd1,
      LOCKED = 2'd2
   } state_t;

   // Successor of a stream word; wraps 8'hFF -> 8'h00.
   function automatic logic [DATA_W-1:0] next_word(
      input logic [DATA_W-1:0] d
   );
      return d + DATA_W'(1);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
// Used for the data_chk statistics.
module sat_counter
   import data_chk_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [WIDTH-1:0] value
);

   // Count up on inc, hold once every bit is set.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         value <= '0;
      end else if (inc && (value != '1)) begin
         value <= value + WIDTH'(1);
      end
   end

endmodule

// File: rtl/data_chk.sv
// data_chk: lock/verify checker for a self-incrementing 8-bit stream.
// Statistics counters exist only when DATA_CHK_STATS_EN is defined.
module data_chk
   import data_chk_pkg::*;
#(
   parameter int LOCK_CNT = 4,
   parameter int LOSS_CNT = 3,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data_in,
   input  logic              data_valid,
   output logic              locked,
   output logic              err,
   output logic [DATA_W-1:0] exp_data,
   output logic [CNT_W-1:0]  rx_count,
   output logic [CNT_W-1:0]  err_count
);

   localparam logic [MC_W-1:0] LOCK_V = MC_W'(LOCK_CNT);
   localparam logic [MC_W-1:0] LOSS_V = MC_W'(LOSS_CNT);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] exp_q, exp_d;
   logic [MC_W-1:0]   match_q, match_d;
   logic [MC_W-1:0]   miss_q, miss_d;
   logic              locked_q, locked_d;
   logic              err_q, err_d;

   logic              hit;
   logic [MC_W-1:0]   match_inc;
   logic [MC_W-1:0]   miss_inc;
   logic [DATA_W-1:0] seed;
   logic [DATA_W-1:0] exp_inc;

   assign hit       = (data_in == exp_q);
   assign match_inc = match_q + MC_W'(1);
   assign miss_inc  = miss_q + MC_W'(1);
   assign seed      = next_word(data_in);
   assign exp_inc   = next_word(exp_q);

   // State and output registers; everything visible is registered.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         exp_q    <= '0;
         match_q  <= '0;
         miss_q   <= '0;
         locked_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         exp_q    <= exp_d;
         match_q  <= match_d;
         miss_q   <= miss_d;
         locked_q <= locked_d;
         err_q    <= err_d;
      end
   end

   // Next-state: acquire in SYNC, tolerate isolated errors in LOCKED.
   always_comb begin
      state_d  = state_q;
      exp_d    = exp_q;
      match_d  = match_q;
      miss_d   = miss_q;
      locked_d = locked_q;
      err_d    = 1'b0;
      if (data_valid) begin
         unique case (state_q)
            IDLE: begin
               exp_d    = seed;
               match_d  = MC_W'(1);
               miss_d   = '0;
               locked_d = 1'b0;
               state_d  = SYNC;
            end
            SYNC: begin
               if (hit) begin
                  exp_d   = exp_inc;
                  match_d = match_inc;
                  if (match_inc == LOCK_V) begin
                     state_d  = LOCKED;
                     locked_d = 1'b1;
                     miss_d   = '0;
                  end
               end else begin
                  exp_d   = seed;
                  match_d = MC_W'(1);
               end
            end
            LOCKED: begin
               if (hit) begin
                  exp_d  = exp_inc;
                  miss_d = '0;
               end else begin
                  err_d = 1'b1;
                  if (miss_inc == LOSS_V) begin
                     state_d  = SYNC;
                     exp_d    = seed;
                     match_d  = MC_W'(1);
                     miss_d   = '0;
                     locked_d = 1'b0;
                  end else begin
                     exp_d  = exp_inc;
                     miss_d = miss_inc;
                  end
               end
            end
            default: begin
               state_d  = IDLE;
               locked_d = 1'b0;
            end
         endcase
      end
   end

   assign locked   = locked_q;
   assign err      = err_q;
   assign exp_data = exp_q;

`ifdef DATA_CHK_STATS_EN
   sat_counter #(
      .WIDTH (CNT_W)
   ) u_rx_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (data_valid),
      .value (rx_count)
   );

   sat_counter #(
      .WIDTH (CNT_W)
   ) u_err_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (err_d),
      .value (err_count)
   );
`else
   assign rx_count  = '0;
   assign err_count = '0;
`endif

endmodule

// File: tb/tb_data_chk.sv
// tb_data_chk: directed bench for data_chk.
// Expected statistics follow DATA_CHK_STATS_EN.
module tb_data_chk;

   logic       clk;
   logic       rst;
   logic [7:0] data_in;
   logic       data_valid;
   logic       locked;
   logic       err;
   logic [7:0] exp_data;
   logic [7:0] rx_count;
   logic [7:0] err_count;

   int n_chk;
   int n_fail;

`ifdef DATA_CHK_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   data_chk #(
      .LOCK_CNT (4),
      .LOSS_CNT (3),
      .CNT_W    (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .data_in    (data_in),
      .data_valid (data_valid),
      .locked     (locked),
      .err        (err),
      .exp_data   (exp_data),
      .rx_count   (rx_count),
      .err_count  (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input logic v, input logic [7:0] d);
      data_valid = v;
      data_in    = d;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      data_valid = 1'b0;
      data_in    = 8'h00;
      rst        = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic lock_on(input logic [7:0] base);
      for (int i = 0; i < 4; i++) step(1'b1, base + 8'(i));
   endtask

   task automatic test_reset();
      rst        = 1'b0;
      data_valid = 1'b1;
      data_in    = 8'h10;
      @(posedge clk);
      #1;
      n_chk++;
      if (locked !== 1'b0 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_flags: locked=%b err=%b want 0 0", locked, err);
      end
      n_chk++;
      if (exp_data !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_exp: got %h want 00", exp_data);
      end
      n_chk++;
      if (rx_count !== 8'h00 || err_count !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_cnt: rx=%0d err=%0d want 0 0", rx_count, err_count);
      end
      do_reset();
   endtask

   task automatic test_lock();
      logic [7:0] d [4];
      logic [7:0] e [4];
      logic       l [4];
      d = '{8'h10, 8'h11, 8'h12, 8'h13};
      e = '{8'h11, 8'h12, 8'h13, 8'h14};
      l = '{1'b0, 1'b0, 1'b0, 1'b1};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         step(1'b1, d[i]);
         n_chk++;
         if (locked !== l[i] || err !== 1'b0 || exp_data !== e[i]) begin
            n_fail++;
            $display("FAIL lock_%0d: locked=%b err=%b exp=%h want %b 0 %h",
                     i, locked, err, exp_data, l[i], e[i]);
         end
         if (i == 1) begin
            step(1'b0, 8'h99);
            n_chk++;
            if (exp_data !== 8'h12 || err !== 1'b0 || locked !== 1'b0) begin
               n_fail++;
               $display("FAIL idle_hold: exp=%h err=%b locked=%b want 12 0 0",
                        exp_data, err, locked);
            end
         end
      end
      step(1'b0, 8'h55);
      n_chk++;
      if (locked !== 1'b1 || exp_data !== 8'h14 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL lock_hold: locked=%b exp=%h err=%b want 1 14 0",
                  locked, exp_data, err);
      end
      n_chk++;
      if (rx_count !== (STATS ? 8'd4 : 8'd0)) begin
         n_fail++;
         $display("FAIL lock_rx: got %0d want %0d", rx_count, STATS ? 4 : 0);
      end
   endtask

   task automatic test_sync_reseed();
      logic [7:0] d [6];
      logic [7:0] e [6];
      logic       l [6];
      d = '{8'h30, 8'h31, 8'h50, 8'h51, 8'h52, 8'h53};
      e = '{8'h31, 8'h32, 8'h51, 8'h52, 8'h53, 8'h54};
      l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         step(1'b1, d[i]);
         n_chk++;
         if (locked !== l[i] || err !== 1'b0 || exp_data !== e[i]) begin
            n_fail++;
            $display("FAIL reseed_%0d: locked=%b err=%b exp=%h want %b 0 %h",
                     i, locked, err, exp_data, l[i], e[i]);
         end
      end
   endtask

   task automatic test_wrap();
      logic [7:0] d [4];
      logic [7:0] e [4];
      d = '{8'hFE, 8'hFF, 8'h00, 8'h01};
      e = '{8'hFF, 8'h00, 8'h01, 8'h02};
      do_reset();
      lock_on(8'hFA);
      n_chk++;
      if (locked !== 1'b1) begin
         n_fail++;
         $display("FAIL wrap_lock: locked=%b want 1", locked);
      end
      for (int i = 0; i < 4; i++) begin
         step(1'b1, d[i]);
         n_chk++;
         if (locked !== 1'b1 || err !== 1'b0 || exp_data !== e[i]) begin
            n_fail++;
            $display("FAIL wrap_%0d: locked=%b err=%b exp=%h want 1 0 %h",
                     i, locked, err, exp_data, e[i]);
         end
      end
   endtask

   task automatic test_single_err();
      logic [7:0] d [4];
      logic [7:0] e [4];
      logic       r [4];
      d = '{8'h20, 8'h21, 8'h77, 8'h23};
      e = '{8'h21, 8'h22, 8'h23, 8'h24};
      r = '{1'b0, 1'b0, 1'b1, 1'b0};
      do_reset();
      lock_on(8'h1C);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, d[i]);
         n_chk++;
         if (locked !== 1'b1 || err !== r[i] || exp_data !== e[i]) begin
            n_fail++;
            $display("FAIL single_%0d: locked=%b err=%b exp=%h want 1 %b %h",
                     i, locked, err, exp_data, r[i], e[i]);
         end
      end
      n_chk++;
      if (err_count !== (STATS ? 8'd1 : 8'd0) ||
          rx_count !== (STATS ? 8'd8 : 8'd0)) begin
         n_fail++;
         $display("FAIL single_cnt: err_count=%0d rx=%0d want %0d %0d",
                  err_count, rx_count, STATS ? 1 : 0, STATS ? 8 : 0);
      end
   endtask

   task automatic test_loss();
      logic [7:0] d [10];
      logic [7:0] e [10];
      logic       r [10];
      logic       l [10];
      d = '{8'h24, 8'hA0, 8'hA1, 8'h27, 8'hAA,
            8'hBB, 8'hCC, 8'hCD, 8'hCE, 8'hCF};
      e = '{8'h25, 8'h26, 8'h27, 8'h28, 8'h29,
            8'h2A, 8'hCD, 8'hCE, 8'hCF, 8'hD0};
      r = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
            1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      l = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
            1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 10; i++) begin
         step(1'b1, d[i]);
         n_chk++;
         if (locked !== l[i] || err !== r[i] || exp_data !== e[i]) begin
            n_fail++;
            $display("FAIL loss_%0d: locked=%b err=%b exp=%h want %b %b %h",
                     i, locked, err, exp_data, l[i], r[i], e[i]);
         end
      end
      n_chk++;
      if (err_count !== (STATS ? 8'd6 : 8'd0) ||
          rx_count !== (STATS ? 8'd18 : 8'd0)) begin
         n_fail++;
         $display("FAIL loss_cnt: err_count=%0d rx=%0d want %0d %0d",
                  err_count, rx_count, STATS ? 6 : 0, STATS ? 18 : 0);
      end
   endtask

   task automatic test_const();
      int bad;
      bad = 0;
      do_reset();
      for (int i = 0; i < 100; i++) begin
         step(1'b1, 8'hFF);
         if (locked !== 1'b0 || err !== 1'b0) bad++;
      end
      n_chk++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL const_flags: %0d cycles with locked/err set, want 0", bad);
      end
      n_chk++;
      if (exp_data !== 8'h00) begin
         n_fail++;
         $display("FAIL const_exp: got %h want 00", exp_data);
      end
      n_chk++;
      if (rx_count !== (STATS ? 8'd100 : 8'd0)) begin
         n_fail++;
         $display("FAIL const_rx: got %0d want %0d", rx_count, STATS ? 100 : 0);
      end
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 155; i++) step(1'b1, 8'hFF);
      n_chk++;
      if (rx_count !== (STATS ? 8'd255 : 8'd0)) begin
         n_fail++;
         $display("FAIL sat_full: got %0d want %0d", rx_count, STATS ? 255 : 0);
      end
      for (int i = 0; i < 5; i++) step(1'b1, 8'hFF);
      n_chk++;
      if (rx_count !== (STATS ? 8'd255 : 8'd0)) begin
         n_fail++;
         $display("FAIL sat_hold: got %0d want %0d", rx_count, STATS ? 255 : 0);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] d [4];
      logic       l [4];
      d = '{8'h05, 8'h06, 8'h07, 8'h08};
      l = '{1'b0, 1'b0, 1'b0, 1'b1};
      do_reset();
      lock_on(8'h40);
      n_chk++;
      if (locked !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_prelock: locked=%b want 1", locked);
      end
      data_valid = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      n_chk++;
      if (locked !== 1'b0 || exp_data !== 8'h00 || rx_count !== 8'h00) begin
         n_fail++;
         $display("FAIL mid_async: locked=%b exp=%h rx=%0d want 0 00 0",
                  locked, exp_data, rx_count);
      end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         step(1'b1, d[i]);
         n_chk++;
         if (locked !== l[i] || err !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_relock_%0d: locked=%b err=%b want %b 0",
                     i, locked, err, l[i]);
         end
      end
      n_chk++;
      if (exp_data !== 8'h09) begin
         n_fail++;
         $display("FAIL mid_exp: got %h want 09", exp_data);
      end
   endtask

   initial begin
      n_chk      = 0;
      n_fail     = 0;
      rst        = 1'b0;
      data_valid = 1'b0;
      data_in    = 8'h00;
      test_reset();
      test_lock();
      test_sync_reseed();
      test_wrap();
      test_single_err();
      test_loss();
      test_const();
      test_saturate();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/data_chk.md
DATA_CHK -- requirements
Module: data_chk

Interface
REQ-001 Parameter LOCK_CNT, default 4, consecutive in-sequence samples needed to declare lock (range 2..15).
REQ-002 Parameter LOSS_CNT, default 3, consecutive mismatches in LOCKED that force loss of lock (range 1..15).
REQ-003 Parameter CNT_W, default 16, width of statistics counters.
REQ-004 clk  input  1  the single clock; all logic on posedge clk.
REQ-005 rst  input  1  reset, asynchronous and active-low.
REQ-006 data_in  input  8  incoming stream word from the self-incrementing 8-bit data source.
REQ-007 data_valid  input  1  data_in is sampled on a posedge where data_valid=1; no backpressure.
REQ-008 locked  output  1  high while the checker is in LOCKED.
REQ-009 err  output  1  one-cycle pulse per mismatching sample while LOCKED.
REQ-010 exp_data  output  8  value expected on the next valid sample.
REQ-011 rx_count  output  CNT_W  count of valid samples accepted (statistics).
REQ-012 err_count  output  CNT_W  count of err pulses (statistics).

Function
REQ-013 States IDLE, SYNC, LOCKED; all outputs registered; response appears the cycle after the sampling edge (latency 1).
REQ-014 Cycles with data_valid=0 change no state, counters or outputs; err is 0.
REQ-015 Match rule: data_in == exp_data; exp_data is always (accepted reference + 1) mod 256, so 8'hFF followed by 8'h00 is a match.
REQ-016 IDLE, valid sample: exp_data <= data_in+1, match_cnt <= 1, go to SYNC.
REQ-017 SYNC, match: match_cnt++, exp_data++; when match_cnt reaches LOCK_CNT go to LOCKED, locked=1 next cycle.
REQ-018 SYNC, mismatch: reseed exp_data <= data_in+1, match_cnt <= 1, stay in SYNC; err not asserted.
REQ-019 LOCKED, match: exp_data++, miss_cnt <= 0.
REQ-020 LOCKED, mismatch: err=1 for one cycle, exp_data++ (single corrupted word tolerated), miss_cnt++.
REQ-021 LOCKED, miss_cnt reaching LOSS_CNT: go to SYNC reseeded from the current data_in, match_cnt <= 1, locked=0; err still pulses for this sample.
REQ-022 A constant input stream never achieves lock and never pulses err.
REQ-023 Statistics counters saturate at all-ones and never wrap.

Reset
REQ-024 rst low asynchronously forces IDLE, locked=0, err=0, exp_data=8'h00, match_cnt=0, miss_cnt=0, rx_count=0, err_count=0.
REQ-025 Reset asserted mid-stream discards lock; after release the first valid sample re-seeds per REQ-016.
REQ-026 Reset release is synchronised by the instantiating system; data_chk adds no synchroniser.

Configuration
REQ-027 Macro DATA_CHK_STATS_EN defined: rx_count and err_count implemented per REQ-011/012/023.
REQ-028 Macro undefined: both counters removed, rx_count and err_count ports kept and driven constant 0; all other behaviour identical.

Structure
REQ-029 Package data_chk_pkg holds the state enum (IDLE, SYNC, LOCKED), DATA_W=8 and the match/miss counter width (4).
REQ-030 One sub-module sat_counter (parameter width, inputs clk, rst, inc; output value, saturating) instantiated twice under DATA_CHK_STATS_EN.

Verification
REQ-031 Reset, then valid stream 8'h10,11,12,13 -> locked=1 cycle after 8'h13, exp_data=8'h14, err never 1.
REQ-032 Locked stream crossing 8'hFE,FF,00,01 -> locked stays 1, err stays 0.
REQ-033 Locked, one corrupted word (8'h20,21,77,23) -> single err pulse after 8'h77, locked stays 1, err_count=1 (stats on).
REQ-034 Locked, three consecutive wrong words with LOSS_CNT=3 -> three err pulses, locked=0 after the third, state SYNC.
REQ-035 Constant 8'hFF with data_valid=1 for 100 cycles -> locked=0 and err=0 throughout, rx_count=100 (stats on), 0 (stats off).
REQ-036 Reset asserted while locked, then 8'h05,06,07,08 -> locked drops asynchronously, relocks after 8'h08.
